cpu_alu_issue: RTL and testbench

CPU_ALU_ISSUE -- requirements
Module: cpu_alu_issue

---
 rtl/cpu_alu_pkg.sv | 75 +++++++
 rtl/cpu_alu_decode.sv | 56 +++++
 rtl/cpu_alu_issue.sv | 144 ++++++++++++++
 tb/tb_cpu_alu_issue.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_alu_pkg.sv
// Shared definitions for the ALU issue stage: ALU control codes, RV opcodes,
// skid-buffer state encoding and small decode helpers.
package cpu_alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        SKID_EMPTY,
        SKID_ONE,
        SKID_TWO
    } skid_state_t;

    // sub_ok separates OP (funct7 selects SUB) from OP-IMM (funct7 bits are immediate).
    function automatic logic [3:0] funct3_to_ctrl(input logic [2:0] funct3,
                                                  input logic       alt,
                                                  input logic       sub_ok);
        logic [3:0] ctrl;
        case (funct3)
            3'b000:  ctrl = (alt && sub_ok) ? ALU_SUB : ALU_ADD;
            3'b001:  ctrl = ALU_SLL;
            3'b010:  ctrl = ALU_SLT;
            3'b011:  ctrl = ALU_SLTU;
            3'b100:  ctrl = ALU_XOR;
            3'b101:  ctrl = alt ? ALU_SRA : ALU_SRL;
            3'b110:  ctrl = ALU_OR;
            default: ctrl = ALU_AND;
        endcase
        return ctrl;
    endfunction

    function automatic logic is_illegal(input logic [6:0] opcode,
                                        input logic [2:0] funct3,
                                        input logic [6:0] funct7);
        logic bad;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE)
                    bad = 1'b0;
                else if (funct7 == F7_ALT)
                    bad = !((funct3 == 3'b000) || (funct3 == 3'b101));
                else
                    bad = 1'b1;
            end
            OPC_OP_IMM: begin
                if (funct3 == 3'b001)
                    bad = (funct7 != F7_BASE);
                else if (funct3 == 3'b101)
                    bad = !((funct7 == F7_BASE) || (funct7 == F7_ALT));
                else
                    bad = 1'b0;
            end
            OPC_LUI, OPC_AUIPC: bad = 1'b0;
            default:            bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/cpu_alu_decode.sv
// Combinational field decode of one RV32 integer instruction into ALU operands.
// ALU_ILLEGAL_CHECK_EN enables illegal-encoding detection on the illegal output.
module cpu_alu_decode
    import cpu_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] operand_a,
    output logic [XLEN-1:0] operand_b,
    output logic [3:0]      control,
    output logic            illegal
);

    logic alt;
    assign alt = (funct7 == F7_ALT);

    always_comb begin
        operand_a = rs1_data;
        operand_b = rs2_data;
        control   = ALU_ADD;
        case (opcode)
            OPC_OP: begin
                control = funct3_to_ctrl(funct3, alt, 1'b1);
            end
            OPC_OP_IMM: begin
                operand_b = imm;
                control   = funct3_to_ctrl(funct3, alt, 1'b0);
            end
            OPC_LUI: begin
                operand_a = '0;
                operand_b = imm;
            end
            OPC_AUIPC: begin
                operand_a = pc;
                operand_b = imm;
            end
            default: ;
        endcase
`ifdef ALU_ILLEGAL_CHECK_EN
        // Illegal entries still flow downstream, but as a harmless ADD.
        illegal = is_illegal(opcode, funct3, funct7);
        if (illegal)
            control = ALU_ADD;
`else
        illegal = 1'b0;
`endif
    end

endmodule

// File: rtl/cpu_alu_issue.sv
// ALU issue stage: registered decode feeding a two-entry skid buffer with
// registered in_ready. Build with ALU_ILLEGAL_CHECK_EN to flag illegal encodings.
module cpu_alu_issue
    import cpu_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [6:0]      in_opcode,
    input  logic [2:0]      in_funct3,
    input  logic [6:0]      in_funct7,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_operand_a,
    output logic [XLEN-1:0] out_operand_b,
    output logic [3:0]      out_control,
    output logic            out_illegal
);

    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;
    logic [3:0]      dec_control;
    logic            dec_illegal;

    cpu_alu_decode #(.XLEN(XLEN)) u_decode (
        .opcode    (in_opcode),
        .funct3    (in_funct3),
        .funct7    (in_funct7),
        .pc        (in_pc),
        .rs1_data  (in_rs1_data),
        .rs2_data  (in_rs2_data),
        .imm       (in_imm),
        .operand_a (dec_a),
        .operand_b (dec_b),
        .control   (dec_control),
        .illegal   (dec_illegal)
    );

    skid_state_t     state_reg, state_next;
    logic            in_ready_reg;
    logic [XLEN-1:0] head_a_reg, head_b_reg, tail_a_reg, tail_b_reg;
    logic [3:0]      head_control_reg, tail_control_reg;
    logic            head_illegal_reg, tail_illegal_reg;

    logic accept, drain;
    logic load_head_in, load_head_tail, load_tail;

    assign accept    = in_valid && in_ready_reg;
    assign out_valid = (state_reg != SKID_EMPTY);
    assign drain     = out_valid && out_ready;

    always_comb begin
        state_next     = state_reg;
        load_head_in   = 1'b0;
        load_head_tail = 1'b0;
        load_tail      = 1'b0;
        if (flush) begin
            state_next = SKID_EMPTY;
        end else begin
            case (state_reg)
                SKID_EMPTY: begin
                    if (accept) begin
                        state_next   = SKID_ONE;
                        load_head_in = 1'b1;
                    end
                end
                SKID_ONE: begin
                    if (accept && !drain) begin
                        state_next = SKID_TWO;
                        load_tail  = 1'b1;
                    end else if (accept && drain) begin
                        load_head_in = 1'b1;
                    end else if (drain) begin
                        state_next = SKID_EMPTY;
                    end
                end
                SKID_TWO: begin
                    if (drain) begin
                        state_next     = SKID_ONE;
                        load_head_tail = 1'b1;
                    end
                end
                default: state_next = SKID_EMPTY;
            endcase
        end
    end

    // in_ready comes straight from a flop so upstream timing never sees out_ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= SKID_EMPTY;
            in_ready_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= (state_next != SKID_TWO);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_a_reg       <= '0;
            head_b_reg       <= '0;
            head_control_reg <= ALU_ADD;
            head_illegal_reg <= 1'b0;
            tail_a_reg       <= '0;
            tail_b_reg       <= '0;
            tail_control_reg <= ALU_ADD;
            tail_illegal_reg <= 1'b0;
        end else begin
            if (load_head_in) begin
                head_a_reg       <= dec_a;
                head_b_reg       <= dec_b;
                head_control_reg <= dec_control;
                head_illegal_reg <= dec_illegal;
            end else if (load_head_tail) begin
                head_a_reg       <= tail_a_reg;
                head_b_reg       <= tail_b_reg;
                head_control_reg <= tail_control_reg;
                head_illegal_reg <= tail_illegal_reg;
            end
            if (load_tail) begin
                tail_a_reg       <= dec_a;
                tail_b_reg       <= dec_b;
                tail_control_reg <= dec_control;
                tail_illegal_reg <= dec_illegal;
            end
        end
    end

    assign in_ready      = in_ready_reg;
    assign out_operand_a = head_a_reg;
    assign out_operand_b = head_b_reg;
    assign out_control   = head_control_reg;
    assign out_illegal   = head_illegal_reg;

endmodule

// File: tb/tb_cpu_alu_issue.sv
// Directed self-checking bench for cpu_alu_issue; expectations follow the
// ALU_ILLEGAL_CHECK_EN setting of the build.
module tb_cpu_alu_issue;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [XLEN-1:0] in_pc, in_rs1_data, in_rs2_data, in_imm, out_operand_a, out_operand_b;
    logic [6:0]      in_opcode, in_funct7;
    logic [2:0]      in_funct3;
    logic [3:0]      out_control;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_alu_issue #(.XLEN(XLEN)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc         (in_pc),
        .in_opcode     (in_opcode),
        .in_funct3     (in_funct3),
        .in_funct7     (in_funct7),
        .in_rs1_data   (in_rs1_data),
        .in_rs2_data   (in_rs2_data),
        .in_imm        (in_imm),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_operand_a (out_operand_a),
        .out_operand_b (out_operand_b),
        .out_control   (out_control),
        .out_illegal   (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] rs1;
        logic [31:0] imm;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [3:0]  exp_c;
    } vec_t;

    vec_t vecs[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] pc, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] imm);
        in_valid    = 1'b1;
        in_opcode   = op;
        in_funct3   = f3;
        in_funct7   = f7;
        in_pc       = pc;
        in_rs1_data = rs1;
        in_rs2_data = rs2;
        in_imm      = imm;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        idle();
        drive(7'd0, 3'd0, 7'd0, '0, '0, '0, '0);
        in_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        n_checks++; if (out_operand_a !== 32'd0 || out_operand_b !== 32'd0) begin n_fail++; $display("FAIL reset_operands: got a=%h b=%h want 0/0", out_operand_a, out_operand_b); end
        n_checks++; if (out_control !== 4'd0 || out_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl: got c=%0d ill=%b want 0/0", out_control, out_illegal); end
        $display("reset: valid=%b ready=%b", out_valid, in_ready);
    endtask

    task automatic test_sub();
        out_ready = 1'b1;
        drive(7'b0110011, 3'b000, 7'b0100000, 32'h0, 32'd7, 32'd3, 32'h0);
        tick();
        idle();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sub_valid: got %b want 1", out_valid); end
        n_checks++; if (out_control !== 4'd1) begin n_fail++; $display("FAIL sub_ctrl: got %0d want 1", out_control); end
        n_checks++; if (out_operand_a !== 32'd7 || out_operand_b !== 32'd3) begin n_fail++; $display("FAIL sub_ops: got a=%0d b=%0d want 7/3", out_operand_a, out_operand_b); end
        $display("sub: a=%0d b=%0d c=%0d", out_operand_a, out_operand_b, out_control);
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sub_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_auipc();
        out_ready = 1'b1;
        drive(7'b0010111, 3'b011, 7'b0100000, 32'h1000, 32'hdead, 32'hbeef, 32'h2000);
        tick();
        idle();
        n_checks++; if (out_valid !== 1'b1 || out_control !== 4'd0) begin n_fail++; $display("FAIL auipc_ctrl: got v=%b c=%0d want 1/0", out_valid, out_control); end
        n_checks++; if (out_operand_a !== 32'h1000 || out_operand_b !== 32'h2000) begin n_fail++; $display("FAIL auipc_ops: got a=%h b=%h want 1000/2000", out_operand_a, out_operand_b); end
        $display("auipc: a=%h b=%h c=%0d", out_operand_a, out_operand_b, out_control);
        tick();
    endtask

    task automatic test_decode_table();
        vecs[0]  = '{7'b0110011, 3'b000, 7'h00, 32'h100, 32'h7,        32'h100, 32'h20,       4'd0};
        vecs[1]  = '{7'b0110011, 3'b001, 7'h00, 32'h101, 32'h7,        32'h101, 32'h20,       4'd5};
        vecs[2]  = '{7'b0110011, 3'b010, 7'h00, 32'h102, 32'h7,        32'h102, 32'h20,       4'd8};
        vecs[3]  = '{7'b0110011, 3'b011, 7'h00, 32'h103, 32'h7,        32'h103, 32'h20,       4'd9};
        vecs[4]  = '{7'b0110011, 3'b100, 7'h00, 32'h104, 32'h7,        32'h104, 32'h20,       4'd4};
        vecs[5]  = '{7'b0110011, 3'b101, 7'h00, 32'h105, 32'h7,        32'h105, 32'h20,       4'd6};
        vecs[6]  = '{7'b0110011, 3'b101, 7'h20, 32'h106, 32'h7,        32'h106, 32'h20,       4'd7};
        vecs[7]  = '{7'b0110011, 3'b110, 7'h00, 32'h107, 32'h7,        32'h107, 32'h20,       4'd3};
        vecs[8]  = '{7'b0110011, 3'b111, 7'h00, 32'h108, 32'h7,        32'h108, 32'h20,       4'd2};
        vecs[9]  = '{7'b0010011, 3'b000, 7'h20, 32'h109, 32'h400,      32'h109, 32'h400,      4'd0};
        vecs[10] = '{7'b0010011, 3'b101, 7'h20, 32'h10a, 32'h403,      32'h10a, 32'h403,      4'd7};
        vecs[11] = '{7'b0010011, 3'b001, 7'h00, 32'h10b, 32'h3,        32'h10b, 32'h3,        4'd5};
        vecs[12] = '{7'b0010011, 3'b011, 7'h7f, 32'h10c, 32'hffffffff, 32'h10c, 32'hffffffff, 4'd9};
        vecs[13] = '{7'b0110111, 3'b000, 7'h00, 32'h10d, 32'h12345000, 32'h0,   32'h12345000, 4'd0};
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].op, vecs[i].f3, vecs[i].f7, 32'h0, vecs[i].rs1, 32'h20, vecs[i].imm);
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_control !== vecs[i].exp_c || out_operand_a !== vecs[i].exp_a ||
                out_operand_b !== vecs[i].exp_b || out_illegal !== 1'b0) begin
                n_fail++;
                $display("FAIL decode_%0d: got v=%b a=%h b=%h c=%0d ill=%b want v=1 a=%h b=%h c=%0d ill=0",
                         i, out_valid, out_operand_a, out_operand_b, out_control, out_illegal,
                         vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_c);
            end
            $display("decode %0d: a=%h b=%h c=%0d", i, out_operand_a, out_operand_b, out_control);
        end
        idle();
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL decode_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(7'b0110011, 3'b000, 7'h00, 32'h0, 32'd1, 32'd11, 32'h0);
        tick();
        n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_operand_a !== 32'd1) begin n_fail++; $display("FAIL b2b_first: got v=%b r=%b a=%0d want 1/1/1", out_valid, in_ready, out_operand_a); end
        drive(7'b0110011, 3'b000, 7'h00, 32'h0, 32'd2, 32'd12, 32'h0);
        tick();
        drive(7'b0110011, 3'b000, 7'h00, 32'h0, 32'd3, 32'd13, 32'h0);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready: got %b want 0", in_ready); end
        n_checks++; if (out_operand_a !== 32'd1 || out_operand_b !== 32'd11) begin n_fail++; $display("FAIL b2b_stable: got a=%0d b=%0d want 1/11", out_operand_a, out_operand_b); end
        tick();
        n_checks++; if (in_ready !== 1'b0 || out_operand_a !== 32'd1) begin n_fail++; $display("FAIL b2b_hold: got r=%b a=%0d want 0/1", in_ready, out_operand_a); end
        idle();
        out_ready = 1'b1;
        $display("b2b drain: a=%0d", out_operand_a);
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_operand_a !== 32'd2 || out_operand_b !== 32'd12 || in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_second: got v=%b a=%0d b=%0d r=%b want 1/2/12/1", out_valid, out_operand_a, out_operand_b, in_ready); end
        $display("b2b drain: a=%0d", out_operand_a);
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_no_third: got v=%b a=%0d want v=0", out_valid, out_operand_a); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(7'b0110011, 3'b000, 7'h00, 32'h0, 32'd21, 32'd0, 32'h0);
        tick();
        drive(7'b0110011, 3'b000, 7'h00, 32'h0, 32'd22, 32'd0, 32'h0);
        tick();
        drive(7'b0110011, 3'b000, 7'h00, 32'h0, 32'd23, 32'd0, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_two: got v=%b r=%b want 0/1", out_valid, in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_two_gone: got v=%b a=%0d want v=0", out_valid, out_operand_a); end
        drive(7'b0110011, 3'b000, 7'h00, 32'h0, 32'd24, 32'd0, 32'h0);
        tick();
        drive(7'b0110011, 3'b000, 7'h00, 32'h0, 32'd25, 32'd0, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        tick();
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_accept: got v=%b r=%b want 0/1", out_valid, in_ready); end
        $display("flush: valid=%b ready=%b", out_valid, in_ready);
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        drive(7'b0110011, 3'b000, 7'b0000001, 32'h0, 32'd10, 32'd20, 32'h0);
        tick();
`ifdef ALU_ILLEGAL_CHECK_EN
        n_checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_control !== 4'd0) begin n_fail++; $display("FAIL ill_mul: got v=%b ill=%b c=%0d want 1/1/0", out_valid, out_illegal, out_control); end
`else
        n_checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b0 || out_control !== 4'd0) begin n_fail++; $display("FAIL ill_mul: got v=%b ill=%b c=%0d want 1/0/0", out_valid, out_illegal, out_control); end
`endif
        drive(7'b1111111, 3'b100, 7'h00, 32'h0, 32'd30, 32'd40, 32'h55);
        tick();
`ifdef ALU_ILLEGAL_CHECK_EN
        n_checks++; if (out_illegal !== 1'b1 || out_control !== 4'd0) begin n_fail++; $display("FAIL ill_opcode: got ill=%b c=%0d want 1/0", out_illegal, out_control); end
        drive(7'b0110011, 3'b111, 7'b0100000, 32'h0, 32'd1, 32'd2, 32'h0);
        tick();
        n_checks++; if (out_illegal !== 1'b1 || out_control !== 4'd0) begin n_fail++; $display("FAIL ill_alt_and: got ill=%b c=%0d want 1/0", out_illegal, out_control); end
        drive(7'b0010011, 3'b001, 7'b0100000, 32'h0, 32'd1, 32'd2, 32'h401);
        tick();
        n_checks++; if (out_illegal !== 1'b1 || out_control !== 4'd0) begin n_fail++; $display("FAIL ill_slli: got ill=%b c=%0d want 1/0", out_illegal, out_control); end
`else
        n_checks++; if (out_illegal !== 1'b0 || out_control !== 4'd0 || out_operand_a !== 32'd30 || out_operand_b !== 32'd40) begin n_fail++; $display("FAIL ill_opcode: got ill=%b c=%0d a=%0d b=%0d want 0/0/30/40", out_illegal, out_control, out_operand_a, out_operand_b); end
`endif
        drive(7'b0010011, 3'b000, 7'b0100000, 32'h0, 32'd5, 32'd2, 32'h400);
        tick();
        n_checks++; if (out_illegal !== 1'b0 || out_control !== 4'd0 || out_operand_b !== 32'h400) begin n_fail++; $display("FAIL ill_addi_legal: got ill=%b c=%0d b=%h want 0/0/400", out_illegal, out_control, out_operand_b); end
        $display("illegal: last ill=%b c=%0d", out_illegal, out_control);
        idle();
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(7'b0110011, 3'b000, 7'h00, 32'h0, 32'd41, 32'd0, 32'h0);
        tick();
        drive(7'b0110011, 3'b000, 7'h00, 32'h0, 32'd42, 32'd0, 32'h0);
        tick();
        idle();
        n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_full: got r=%b v=%b want 0/1", in_ready, out_valid); end
        #1 reset = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_async: got v=%b want 0", out_valid); end
        #2 reset = 1'b0;
        tick();
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_release: got r=%b v=%b want 1/0", in_ready, out_valid); end
        n_checks++; if (out_operand_a !== 32'd0 || out_control !== 4'd0 || out_illegal !== 1'b0) begin n_fail++; $display("FAIL rstmid_fields: got a=%0d c=%0d ill=%b want 0/0/0", out_operand_a, out_control, out_illegal); end
        $display("reset mid: valid=%b ready=%b", out_valid, in_ready);
    endtask

    initial begin
        test_reset();
        test_sub();
        test_auipc();
        test_decode_table();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
